board_labels_ovl: RTL and testbench

- Pipelined, parametrised overlay for board coordinate labels: file letters above and below the board, rank digits to the left and right.
- Supersedes the fixed-geometry combinational label address generator.
- Drives an external 8x16 font ROM with one cycle of read latency, and merges the glyph pixels into the VGA stream.
- Supports board flip (black-side view), switched only at a frame boundary.
- Sits in the VGA chain after the board/pieces draw stage.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/board_flip_ctrl.sv | 72 +++++++
 rtl/board_labels_ovl.sv | 230 +++++++++++++++++++++++
 tb/tb_board_labels_ovl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Purpose : Constants and types shared along the VGA drawing chain. This file
//           holds the board coordinate label geometry (glyph size and label
//           band offsets), the ASCII bases for file/rank codes, the flip FSM
//           state type and a helper that packs a font ROM address.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package vga_pkg;

  // Font glyph cell.
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  // File letters sit in horizontal bands above and below the board.
  // FAR is the band edge furthest from the board; NEAR is the closest edge.
  localparam int FILE_BAND_FAR  = 24;
  localparam int FILE_BAND_NEAR = 9;

  // Rank digits sit in vertical bands left and right of the board.
  localparam int RANK_BAND_FAR  = 20;
  localparam int RANK_BAND_NEAR = 13;

  // ASCII bases: 'A' for files, '1' for ranks.
  localparam int FILE_CHAR0 = 65;
  localparam int RANK_CHAR0 = 49;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } flip_state_t;

  // Font ROM address layout: {character code, glyph line}.
  function automatic logic [10:0] font_addr(input logic [6:0] code,
                                            input logic [3:0] line);
    return {code, line};
  endfunction

endpackage

// File: rtl/board_flip_ctrl.sv
// ----------------------------------------------------------------------------
// board_flip_ctrl
// Purpose : Board orientation control. A flip request is held pending and
//           applied only at the next frame start, so the label decode sees one
//           orientation for a whole frame. A second request while pending
//           cancels it.
// Ports   : clk_i           pixel clock
//           rst_ni          synchronous reset, active-low
//           flip_req_i      one-cycle toggle request
//           frame_start_i   high when the pixel at (0,0) is on the inputs
//           flipped_o       registered orientation (1 = black at bottom)
//           flip_pending_o  a flip waits for the next frame start
//           flip_view_o     orientation to use for the pixel currently being
//                           decoded (already the new value on the frame-start
//                           pixel, so the whole new frame is consistent)
// ----------------------------------------------------------------------------
module board_flip_ctrl
  import vga_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flip_req_i,
  input  logic frame_start_i,
  output logic flipped_o,
  output logic flip_pending_o,
  output logic flip_view_o
);

  flip_state_t state_q, state_d;
  logic        flipped_q, flipped_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      flipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flipped_q <= flipped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flipped_d = flipped_q;
    case (state_q)
      // A request that coincides with a frame start only arms the flip; being
      // in PENDING requires a later cycle, so it lands on the next frame.
      IDLE: begin
        if (flip_req_i) begin
          state_d = PENDING;
        end
      end
      // A request always wins over a frame start: the pair counts as a cancel.
      PENDING: begin
        if (flip_req_i) begin
          state_d = IDLE;
        end else if (frame_start_i) begin
          flipped_d = ~flipped_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flipped_o      = flipped_q;
  assign flip_pending_o = (state_q == PENDING);
  assign flip_view_o    = flipped_d;

endmodule

// File: rtl/board_labels_ovl.sv
// ----------------------------------------------------------------------------
// board_labels_ovl
// Purpose : Overlay of board coordinate labels (file letters above/below the
//           board, rank digits left/right) onto the VGA stream. Three stages:
//           S0 decodes region and font address from the input pixel, S1
//           presents the address to an external 8x16 font ROM (one cycle read
//           latency), S2 merges the returned glyph row into the colour.
//           Latency 2 cycles, one pixel per cycle.
// Config  : define BOARD_LABELS_BG_EN to paint LABEL_BG behind glyph pixels
//           (opaque label cells); by default labels are transparent.
// Ports   : clk, rst_n (synchronous, active-low)
//           hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
//           rgb_in        upstream pixel and timing
//           flip_req      one-cycle orientation toggle request
//           char_addr     font ROM address {code[6:0], line[3:0]}
//           char_pixels   font ROM row, one cycle after char_addr, bit 7 left
//           *_out         timing delayed by 2 cycles, merged rgb_out
//           flipped       current orientation, flip_pending flip waiting
// Note    : N_SQ must lie in 2..9 so rank codes stay single digits.
// ----------------------------------------------------------------------------
module board_labels_ovl
  import vga_pkg::*;
#(
  parameter int          BOARD_X0    = 256,
  parameter int          BOARD_Y0    = 128,
  parameter int          SQ_LOG2     = 6,
  parameter int          N_SQ        = 8,
  parameter logic [11:0] LABEL_COLOR = 12'hFFF,
  parameter logic [11:0] LABEL_BG    = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        flip_req,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        flipped,
  output logic        flip_pending
);

`ifdef BOARD_LABELS_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  localparam int SQ  = 1 << SQ_LOG2;
  localparam int BX1 = BOARD_X0 + N_SQ * SQ - 1;
  localparam int BY1 = BOARD_Y0 + N_SQ * SQ - 1;

  // Glyph window centred inside each square.
  localparam int FILE_OX_LO = SQ / 2 - GLYPH_W / 2;
  localparam int FILE_OX_HI = FILE_OX_LO + GLYPH_W - 1;
  localparam int RANK_OY_LO = SQ / 2 - GLYPH_H / 2;
  localparam int RANK_OY_HI = RANK_OY_LO + GLYPH_H - 1;

  localparam int TOP_Y0   = BOARD_Y0 - FILE_BAND_FAR;
  localparam int TOP_Y1   = BOARD_Y0 - FILE_BAND_NEAR;
  localparam int BOT_Y0   = BY1 + FILE_BAND_NEAR;
  localparam int BOT_Y1   = BY1 + FILE_BAND_FAR;
  localparam int LEFT_X0  = BOARD_X0 - RANK_BAND_FAR;
  localparam int LEFT_X1  = BOARD_X0 - RANK_BAND_NEAR;
  localparam int RIGHT_X0 = BX1 + RANK_BAND_NEAR;
  localparam int RIGHT_X1 = BX1 + RANK_BAND_FAR;

  // --------------------------------------------------------------------------
  // Orientation
  // --------------------------------------------------------------------------
  logic frame_start;
  logic flip_view;

  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  board_flip_ctrl u_flip_ctrl (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flip_req_i     (flip_req),
    .frame_start_i  (frame_start),
    .flipped_o      (flipped),
    .flip_pending_o (flip_pending),
    .flip_view_o    (flip_view)
  );

  // --------------------------------------------------------------------------
  // S0: region and address decode
  // Coordinates are widened to signed int, so pixels left of or above the
  // board give negative offsets and cannot wrap into a label window.
  // --------------------------------------------------------------------------
  int          hx, vy, dx, dy, f, r, ox, oy;
  logic        on_cols, on_rows, file_ox, rank_oy;
  logic        top_band, bot_band, left_band, right_band;
  logic        in_file, in_rank;
  logic        in_label_d;
  logic [2:0]  col_d;
  logic [10:0] char_addr_d;

  always_comb begin
    hx = {21'd0, hcount_in};
    vy = {21'd0, vcount_in};
    dx = hx - BOARD_X0;
    dy = vy - BOARD_Y0;
    f  = dx >>> SQ_LOG2;
    r  = dy >>> SQ_LOG2;
    ox = dx & (SQ - 1);
    oy = dy & (SQ - 1);

    on_cols    = (hx >= BOARD_X0) && (hx <= BX1);
    on_rows    = (vy >= BOARD_Y0) && (vy <= BY1);
    file_ox    = (ox >= FILE_OX_LO) && (ox <= FILE_OX_HI);
    rank_oy    = (oy >= RANK_OY_LO) && (oy <= RANK_OY_HI);
    top_band   = (vy >= TOP_Y0) && (vy <= TOP_Y1);
    bot_band   = (vy >= BOT_Y0) && (vy <= BOT_Y1);
    left_band  = (hx >= LEFT_X0) && (hx <= LEFT_X1);
    right_band = (hx >= RIGHT_X0) && (hx <= RIGHT_X1);

    // The bands lie outside the board on the other axis, so the two regions
    // are disjoint and the priority below never matters.
    in_file = on_cols && file_ox && (top_band || bot_band);
    in_rank = on_rows && rank_oy && (left_band || right_band);

    in_label_d  = in_file || in_rank;
    col_d       = 3'd0;
    char_addr_d = 11'd0;

    if (in_file) begin
      col_d       = 3'(ox - FILE_OX_LO);
      char_addr_d = font_addr(
          7'(flip_view ? FILE_CHAR0 + N_SQ - 1 - f : FILE_CHAR0 + f),
          4'(top_band ? vy - TOP_Y0 : vy - BOT_Y0));
    end else if (in_rank) begin
      col_d       = 3'(left_band ? hx - LEFT_X0 : hx - RIGHT_X0);
      // Rank 1 is at the bottom in the normal view, so row 0 shows N_SQ.
      char_addr_d = font_addr(
          7'(flip_view ? RANK_CHAR0 + r : RANK_CHAR0 + N_SQ - 1 - r),
          4'(oy - RANK_OY_LO));
    end
  end

  // --------------------------------------------------------------------------
  // S1: ROM address presented; pixel and timing delayed alongside
  // --------------------------------------------------------------------------
  logic [10:0] char_addr_q;
  logic        in_label_q;
  logic [2:0]  col_q;
  logic [11:0] rgb_s1_q;
  logic [10:0] hcount_s1_q, vcount_s1_q;
  logic [3:0]  sync_s1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_addr_q <= 11'd0;
      in_label_q  <= 1'b0;
      col_q       <= 3'd0;
      rgb_s1_q    <= 12'd0;
      hcount_s1_q <= 11'd0;
      vcount_s1_q <= 11'd0;
      sync_s1_q   <= 4'd0;
    end else begin
      char_addr_q <= char_addr_d;
      in_label_q  <= in_label_d;
      col_q       <= col_d;
      rgb_s1_q    <= rgb_in;
      hcount_s1_q <= hcount_in;
      vcount_s1_q <= vcount_in;
      sync_s1_q   <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
    end
  end

  assign char_addr = char_addr_q;

  // --------------------------------------------------------------------------
  // S2: glyph merge
  // --------------------------------------------------------------------------
  logic        glyph_bit;
  logic [11:0] rgb_d;

  // Bit 7 is the leftmost pixel, so column c reads bit 7-c, i.e. ~c.
  assign glyph_bit = char_pixels[~col_q];

  always_comb begin
    rgb_d = rgb_s1_q;
    if (in_label_q) begin
      if (glyph_bit) begin
        rgb_d = LABEL_COLOR;
      end else if (BG_EN) begin
        rgb_d = LABEL_BG;
      end
    end
  end

  logic [11:0] rgb_out_q;
  logic [10:0] hcount_out_q, vcount_out_q;
  logic [3:0]  sync_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out_q    <= 12'd0;
      hcount_out_q <= 11'd0;
      vcount_out_q <= 11'd0;
      sync_out_q   <= 4'd0;
    end else begin
      rgb_out_q    <= rgb_d;
      hcount_out_q <= hcount_s1_q;
      vcount_out_q <= vcount_s1_q;
      sync_out_q   <= sync_s1_q;
    end
  end

  assign rgb_out    = rgb_out_q;
  assign hcount_out = hcount_out_q;
  assign vcount_out = vcount_out_q;
  assign hsync_out  = sync_out_q[3];
  assign vsync_out  = sync_out_q[2];
  assign hblnk_out  = sync_out_q[1];
  assign vblnk_out  = sync_out_q[0];

endmodule

// File: tb/tb_board_labels_ovl.sv
// ----------------------------------------------------------------------------
// tb_board_labels_ovl
// Purpose : Scoreboard bench for board_labels_ovl. The driver issues directed
//           pixels and pushes expected char_addr / rgb / timing / flip state
//           together with the cycle at which each must appear; a monitor on
//           the falling edge pops and compares every due expectation.
// ----------------------------------------------------------------------------
module tb_board_labels_ovl;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        flip_req;
  logic [10:0] char_addr;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        flipped, flip_pending;

  board_labels_ovl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .hblnk_in     (hblnk_in),
    .vblnk_in     (vblnk_in),
    .rgb_in       (rgb_in),
    .flip_req     (flip_req),
    .char_addr    (char_addr),
    .char_pixels  (char_pixels),
    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .hblnk_out    (hblnk_out),
    .vblnk_out    (vblnk_out),
    .rgb_out      (rgb_out),
    .flipped      (flipped),
    .flip_pending (flip_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_ADDR = 0;
  localparam int K_RGB  = 1;
  localparam int K_TIM  = 2;
  localparam int K_FLIP = 3;
  localparam int K_PEND = 4;

  typedef struct {
    int          kind;
    int          due;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_ADDR:  return {21'd0, char_addr};
      K_RGB:   return {20'd0, rgb_out};
      K_TIM:   return {6'd0, hcount_out, vcount_out,
                       hsync_out, vsync_out, hblnk_out, vblnk_out};
      K_FLIP:  return {31'd0, flipped};
      default: return {31'd0, flip_pending};
    endcase
  endfunction

  // Monitor: compare every expectation that is due this cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d was never compared", sb[i].name, sb[i].due);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        checks++;
        act = actual(sb[i].kind);
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end else begin
          $display("ok   %s: 0x%0h (cycle %0d)", sb[i].name, act, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  logic [7:0] pend_pix = 8'h00;
  int         seq = 0;

  task automatic expect_at(input int kind, input int due, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.due  = due;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // One pixel per clock. The ROM row for a pixel is supplied on the
  // following cycle, mimicking the ROM read latency.
  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                      input logic [7:0] pix, input logic fr);
    hcount_in   = h;
    vcount_in   = v;
    rgb_in      = rgb;
    flip_req    = fr;
    hsync_in    = seq[0];
    vsync_in    = seq[1];
    hblnk_in    = seq[2];
    vblnk_in    = ~seq[0];
    char_pixels = pend_pix;
    pend_pix    = pix;
    seq++;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                     input logic [7:0] pix, input logic [10:0] exp_addr,
                     input logic [11:0] exp_rgb, input string name);
    logic [25:0] tim;
    tim = {h, v, seq[0], seq[1], seq[2], ~seq[0]};
    expect_at(K_ADDR, cyc + 1, {21'd0, exp_addr}, {name, "/addr"});
    expect_at(K_RGB,  cyc + 2, {20'd0, exp_rgb},  {name, "/rgb"});
    expect_at(K_TIM,  cyc + 2, {6'd0, tim},       {name, "/timing"});
    step(h, v, rgb, pix, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b0);
  endtask

  task automatic frame_start(input logic fr);
    step(11'd0, 11'd0, 12'h000, 8'h00, fr);
  endtask

  task automatic check_state(input logic f, input logic p, input string name);
    expect_at(K_FLIP, cyc, {31'd0, f}, {name, "/flipped"});
    expect_at(K_PEND, cyc, {31'd0, p}, {name, "/pending"});
  endtask

  task automatic check_zero(input string name);
    expect_at(K_ADDR, cyc, 32'd0, {name, "/addr"});
    expect_at(K_RGB,  cyc, 32'd0, {name, "/rgb"});
    expect_at(K_TIM,  cyc, 32'd0, {name, "/timing"});
    check_state(1'b0, 1'b0, name);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    hcount_in   = 11'd284;
    vcount_in   = 11'd110;
    rgb_in      = 12'hABC;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    hblnk_in    = 1'b1;
    vblnk_in    = 1'b1;
    flip_req    = 1'b0;
    char_pixels = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Normal orientation.
    vec(11'd284, 11'd110, 12'h0A5, 8'h80, 11'h416, 12'hFFF, "file_top_c0");
    vec(11'd285, 11'd110, 12'h0A5, 8'h80, 11'h416, 12'h0A5, "file_top_c1");
    vec(11'd291, 11'd119, 12'h0A5, 8'h01, 11'h41F, 12'hFFF, "file_top_c7_l15");
    vec(11'd292, 11'd110, 12'h0A5, 8'hFF, 11'h000, 12'h0A5, "file_ox_past");
    vec(11'd284, 11'd103, 12'h0A5, 8'hFF, 11'h000, 12'h0A5, "file_above_band");
    vec(11'd732, 11'd650, 12'h0A5, 8'h80, 11'h482, 12'hFFF, "file_bot_H");
    vec(11'd236, 11'd152, 12'h0A5, 8'h80, 11'h380, 12'hFFF, "rank_left_8");
    vec(11'd787, 11'd615, 12'h0A5, 8'h01, 11'h31F, 12'hFFF, "rank_right_1_l15");
    vec(11'd235, 11'd152, 12'h0A5, 8'hFF, 11'h000, 12'h0A5, "rank_left_edge");
    vec(11'd300, 11'd300, 12'h123, 8'hFF, 11'h000, 12'h123, "outside");
    vec(11'd20,  11'd110, 12'h456, 8'hFF, 11'h000, 12'h456, "left_of_board");
    idle(3);

    // Flip applied at the next frame start.
    step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b1);
    check_state(1'b0, 1'b1, "flip_requested");
    idle(2);
    check_state(1'b0, 1'b1, "flip_waiting");
    frame_start(1'b0);
    check_state(1'b1, 1'b0, "flip_applied");

    vec(11'd284, 11'd110, 12'h0A5, 8'h80, 11'h486, 12'hFFF, "flip_file_H");
    vec(11'd236, 11'd152, 12'h0A5, 8'h00, 11'h310, 12'h0A5, "flip_rank_1");
    vec(11'd732, 11'd650, 12'h0A5, 8'h80, 11'h412, 12'hFFF, "flip_file_bot_A");
    vec(11'd787, 11'd615, 12'h0A5, 8'h01, 11'h38F, 12'hFFF, "flip_rank_right_8");
    idle(3);

    // Two requests before a frame start cancel each other.
    step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b1);
    check_state(1'b1, 1'b1, "cancel_first");
    step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b1);
    check_state(1'b1, 1'b0, "cancel_second");
    frame_start(1'b0);
    check_state(1'b1, 1'b0, "cancel_no_toggle");

    // Request coinciding with frame start while pending also cancels.
    step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b1);
    check_state(1'b1, 1'b1, "fs_cancel_armed");
    frame_start(1'b1);
    check_state(1'b1, 1'b0, "fs_cancel");

    // Reset mid-frame while pending.
    step(11'd1000, 11'd1000, 12'h000, 8'h00, 1'b1);
    check_state(1'b1, 1'b1, "pend_before_rst");
    idle(2);
    rst_n = 1'b0;
    step(11'd284, 11'd110, 12'hABC, 8'hFF, 1'b0);
    check_zero("mid_reset");
    rst_n = 1'b1;
    vec(11'd284, 11'd110, 12'h0A5, 8'h80, 11'h416, 12'hFFF, "post_rst_file");
    vec(11'd236, 11'd152, 12'h0A5, 8'h80, 11'h380, 12'hFFF, "post_rst_rank");
    idle(3);
    check_state(1'b0, 1'b0, "post_rst_state");

    // Request on the frame-start pixel from IDLE lands one frame later.
    frame_start(1'b1);
    check_state(1'b0, 1'b1, "fs_request");
    idle(2);
    frame_start(1'b0);
    check_state(1'b1, 1'b0, "fs_request_applied");

    idle(4);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

endmodule
